// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and frame constants.
//   UART_ADDR_W     width of the bit-period ROM address
//   UART_START_ADDR ROM address of the start bit
//   UART_STOP_ADDR  ROM address of the stop bit
//   UART_DATA_BITS  data bits per frame
package uart_pkg;

  localparam int unsigned UART_ADDR_W     = 4;
  localparam int unsigned UART_START_ADDR = 0;
  localparam int unsigned UART_STOP_ADDR  = 9;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_COUNT    = 3'd3,
    ST_BRK_WAIT = 3'd4
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx pin.
//   CLOCK    in  sole clock
//   RESET    in  synchronous active-high reset; chain resets to 1 (line idle)
//   async_in in  raw pad input
//   sync_out out input delayed through STAGES flops
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift toward the MSB; the MSB is the synchronized output.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule : uart_rx_sync

// File: rtl/uart_rx_bit_sequencer.sv
// UART RX controller: detects the start edge, walks the bit-period ROM over
// start/data/stop addresses, times each bit with a down-counter loaded from
// the ROM and assembles the received byte.
//   CLOCK     in  sole clock
//   RESET     in  synchronous active-high reset
//   en        in  receiver enable; low aborts any frame in progress
//   rx        in  asynchronous serial line, idle high
//   rom_addr  out bit-period ROM address
//   rom_data  in  ROM count, valid one cycle after rom_addr changes
//   rx_data   out last good byte, held until the next good frame
//   rx_valid  out one-cycle pulse: good frame received
//   frame_err out one-cycle pulse: stop bit sampled low
//   busy      out high whenever not IDLE
module uart_rx_bit_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LAST_ADDR   = UART_STOP_ADDR
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   en,
  input  logic                   rx,
  output logic [UART_ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]       rom_data,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int unsigned DB = UART_DATA_BITS;

  logic                   rx_s;
  rx_state_e              state_q,     state_d;
  logic [UART_ADDR_W-1:0] rom_addr_q,  rom_addr_d;
  logic [WIDTH-1:0]       cnt_q,       cnt_d;
  logic [DB-1:0]          shreg_q,     shreg_d;
  logic [7:0]             rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q,      busy_d;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .async_in (rx),
    .sync_out (rx_s)
  );

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (!en && (state_q != ST_IDLE)) begin
      // Abort: drop the partial byte and park the ROM address.
      state_d    = ST_IDLE;
      rom_addr_d = '0;
      shreg_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && !rx_s) begin
            rom_addr_d = UART_ADDR_W'(UART_START_ADDR);
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          cnt_d   = rom_data;
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
          end else if (rom_addr_q == UART_ADDR_W'(UART_START_ADDR)) begin
            // Start bit must still be low at mid-bit, else it was a glitch.
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              rom_addr_d = UART_ADDR_W'(1);
              state_d    = ST_FETCH;
            end
          end else if (rom_addr_q == UART_ADDR_W'(LAST_ADDR)) begin
            if (rx_s) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BRK_WAIT;
            end
          end else begin
            // LSB arrives first, so shift in from the top.
            shreg_d    = {rx_s, shreg_q[DB-1:1]};
            rom_addr_d = rom_addr_q + UART_ADDR_W'(1);
            state_d    = ST_FETCH;
          end
        end
        ST_BRK_WAIT: begin
          // Hold off start detection until the break releases.
          if (rx_s) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule : uart_rx_bit_sequencer
